sigma_seq: RTL and testbench
============================

# sigma_seq

Serial neuron-sum sequencer for the MLP feed-forward datapath. It time-multiplexes one instance of the team's combinational signed-magnitude `adder` to sum a run-time-selected number of `N`-bit operands (`N`, `F` from `config.svh`). Operands arrive one per cycle over a valid/ready stream, and one sum is returned per job. It replaces fixed-fan-in trees like the three-input sum wherever the fan-in varies per layer or adder area must be shared.

## Interface
- `MAXK`, default 16: maximum operands per job. `LW = $clog2(MAXK+1)`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: job request. Sampled only in IDLE.
- `len`  in  LW: operand count for the job, latched on accepted `start`.
- `busy`  out  1: high in every state except IDLE.
- `in_valid`  in  1: operand valid.
- `in_data`  in  `N`: signed-magnitude operand. Bit `N`-1 is the sign; `F` fraction bits.
- `in_ready`  out  1: block accepts an operand this cycle.
- `out_valid`  out  1: sum available.
- `out_data`  out  `N`: signed-magnitude sum.
- `out_ready`  in  1: consumer takes the sum.

## Operation
- States are IDLE, ACC and DONE.
- Registers: `acc[N-1:0]`, `cnt[LW-1:0]`, `len_q[LW-1:0]`.
- **IDLE**
  - `start`=1: latch `len_q = min(len, MAXK)`, clear `acc` and `cnt` to 0.
  - Go to ACC if `len_q`≠0; otherwise go straight to DONE with `acc`=0.
- **ACC**
  - `in_ready`=1.
  - On each cycle with `in_valid && in_ready`:
    - `acc <= adder(acc, in_data)`.
    - `cnt <= cnt+1`.
  - When the accepted operand is number `len_q` (`cnt == len_q-1`), go to DONE.
  - Cycles with `in_valid`=0 are stalls; state is unchanged.
- **DONE**
  - `out_valid`=1 and `out_data = acc`. Both are held stable until `out_valid && out_ready`, then go to IDLE.
- **Arithmetic**
  - Entirely delegated to the single `adder` instance: `a = acc`, `b = in_data`.
  - No extra rounding, saturation or width growth. Overflow behaviour is whatever `adder` produces.
  - Negative zero (0x8000 for N=16) is a legal operand and passes through unaltered.
- **`start` outside IDLE** is ignored; `len` is not re-latched.
- **`in_valid` outside ACC** is ignored. `in_ready`=0 there, so no operand is consumed.
- **Reset** (any state, including mid-job): state=IDLE; `acc`, `cnt`, `len_q` = 0; `busy`, `in_ready`, `out_valid` = 0; `out_data` = 0. The partial sum is discarded and no output is produced.

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from any input to any output.
- `start` accepted at edge E: `busy` and `in_ready` are high from E+1.
- Each accepted operand updates `acc` at the same edge. Throughput is one operand per cycle.
- Last operand accepted at edge L: `out_valid`=1 from L+1.
- Minimum job latency is `len_q`+1 cycles from the `start` edge to `out_valid`, with no stalls.
- `len`=0: `out_valid`=1 at E+1 with `out_data`=0. ACC is skipped.
- `out_valid && out_ready` at edge H: IDLE and `busy`=0 at H+1. A new `start` is accepted at H+1 at the earliest, so there are 2 cycles of overhead between jobs.
- `out_ready` held low holds DONE indefinitely. `in_ready` stays 0 for that whole time (backpressure).

## Test plan
(N=16, F=8.)
- **Basic 3-operand job.** `start` with `len`=3; operands 0x0180 (+1.5), 0x8080 (−0.5), 0x0200 (+2.0), one per cycle; `out_ready`=1.
  - `out_valid` 4 cycles after the `start` edge.
  - `out_data`=0x0300 (+3.0), then `busy`=0 one cycle later.
- **Stalled input.** Same job with `in_valid` low for 2 cycles between operands 1 and 2.
  - Same 0x0300 result.
  - `out_valid` is delayed by exactly 2 cycles.
  - Exactly 3 operands consumed.
- **Output backpressure.** `out_ready`=0 for 5 cycles in DONE.
  - `out_valid` and `out_data` stay stable; `in_ready`=0.
  - A `start` pulse during DONE is ignored.
  - After `out_ready`=1, IDLE follows next cycle.
- **Zero-length and clamp.**
  - `len`=0 gives `out_valid` on the next cycle with 0x0000.
  - `len`=20 with MAXK=16 consumes exactly 16 operands of 0x0010; sum 0x0100. The 17th operand is left unconsumed (`in_ready`=0).
- **Reset mid-job.** Assert `rst` after 2 of 4 operands.
  - Next cycle: all outputs 0, state IDLE.
  - A new `len`=1 job with 0x8100 returns 0x8100, with no residue from the aborted job.
- **Back-to-back jobs.** Job A (`len`=2: 0x0100, 0x0100) then `start` on the first IDLE cycle for job B (`len`=1: 0x8040).
  - Outputs are 0x0200, then 0x8040.
  - Inter-job gap is exactly 2 cycles.

Source files
------------

// File: rtl/sigma_seq.sv
// sigma_seq: serial neuron-sum sequencer. One shared signed-magnitude adder
// accumulates a run-time-selected number of N-bit operands (1..MAXK) that
// arrive over a valid/ready stream, and returns one sum per job.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start, len           job request (sampled in IDLE only), operand count
//   busy                 high in every state except IDLE
//   in_valid, in_data    operand stream; in_ready high only while accumulating
//   out_valid, out_data  sum, held stable until out_ready
//   out_ready            consumer takes the sum
//
// Every output is a register, so no input reaches an output combinationally.
// N is the operand width (sign bit at N-1, magnitude below it).

// Combinational signed-magnitude adder. Magnitude overflow wraps.
// When the operands cancel exactly the result is +0, except that two zero
// operands keep b's sign, so a lone negative-zero operand survives an
// accumulator that starts at +0.
module adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s
);
   localparam int M = N - 1;

   logic         sa;
   logic         sb;
   logic [M-1:0] ma;
   logic [M-1:0] mb;

   assign sa = a[N-1];
   assign sb = b[N-1];
   assign ma = a[M-1:0];
   assign mb = b[M-1:0];

   always_comb begin
      s = '0;
      if (sa == sb) begin
         s = {sa, ma + mb};
      end else if (ma > mb) begin
         s = {sa, ma - mb};
      end else if (mb > ma) begin
         s = {sb, mb - ma};
      end else begin
         s = {((ma == '0) ? sb : 1'b0), {M{1'b0}}};
      end
   end
endmodule

module sigma_seq #(
   parameter int N    = 16,
   parameter int MAXK = 16,
   parameter int LW   = $clog2(MAXK + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          busy,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [N-1:0]  out_data,
   input  logic          out_ready
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  acc;
   logic [LW-1:0] cnt;
   logic [LW-1:0] len_q;
   logic [N-1:0]  sum;
   logic [LW-1:0] len_clamped;

   adder #(.N(N)) u_adder (
      .a (acc),
      .b (in_data),
      .s (sum)
   );

   assign len_clamped = (len > LW'(MAXK)) ? LW'(MAXK) : len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q <= len_clamped;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  if (len_clamped != '0) begin
                     state    <= ACC;
                     in_ready <= 1'b1;
                  end else begin
                     // Empty job: present the cleared accumulator directly.
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= '0;
                  end
               end
            end

            ACC: begin
               // in_ready is registered high throughout ACC, so in_valid
               // alone marks an accepted operand here.
               if (in_valid) begin
                  acc <= sum;
                  cnt <= cnt + LW'(1);
                  if (cnt == len_q - LW'(1)) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= sum;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  out_data  <= '0;
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               out_data  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sigma_seq.sv
// Bench for sigma_seq (N=16, MAXK=16): directed jobs; expected sums are
// queued when a job is issued and checked by an independent output monitor.
module tb_sigma_seq;
   localparam int N    = 16;
   localparam int MAXK = 16;
   localparam int LW   = $clog2(MAXK + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic          out_ready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_acc = 0;
   logic [N-1:0] sb_q[$];

   sigma_seq #(.N(N), .MAXK(MAXK)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) n_acc <= n_acc + 1;
   end

   // Scoreboard monitor: every completed output handshake pops one expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got out_data=%h with nothing expected", out_data);
         end else begin
            logic [N-1:0] e;
            e = sb_q.pop_front();
            if (out_data !== e) begin
               bad++;
               $display("FAIL sb_sum: got %h expected %h", out_data, e);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns the edge count at which start was sampled.
   task automatic do_start(input int l, output int e);
      start = 1'b1;
      len   = LW'(l);
      tick();
      e     = cyc;
      start = 1'b0;
   endtask

   task automatic send(input logic [N-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready never rose for operand %h", d);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Returns the edge count after which out_valid is first seen high.
   task automatic wait_out(output int c);
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("FAIL out_timeout: out_valid never rose");
      end
      c = cyc;
   endtask

   initial begin
      int e, c, base, e2, c2;
      rst = 1'b1; start = 1'b0; len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_busy",      32'(busy),      0);
      chk("reset_in_ready",  32'(in_ready),  0);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_out_data",  32'(out_data),  0);

      // Basic 3-operand job: 1.5 - 0.5 + 2.0 = 3.0.
      sb_q.push_back(16'h0300);
      do_start(3, e);
      chk("basic_busy", 32'(busy), 1);
      send(16'h0180); send(16'h8080); send(16'h0200);
      wait_out(c);
      // Visible after edge E+3, i.e. the 4th cycle counted from the start edge.
      chk("basic_latency", 32'(c - e), 3);
      tick();
      chk("basic_idle_busy", 32'(busy), 0);

      // Stalled input: two idle cycles between operands 1 and 2.
      sb_q.push_back(16'h0300);
      base = n_acc;
      do_start(3, e);
      send(16'h0180);
      tick(); tick();
      send(16'h8080); send(16'h0200);
      wait_out(c);
      chk("stall_latency", 32'(c - e), 5);
      chk("stall_consumed", 32'(n_acc - base), 3);
      tick();

      // Output backpressure with an ignored start pulse during DONE.
      out_ready = 1'b0;
      sb_q.push_back(16'h0200);
      do_start(2, e);
      send(16'h0180); send(16'h0080);
      wait_out(c);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_out_data",  32'(out_data),  32'h0200);
         chk("bp_in_ready",  32'(in_ready),  0);
         start = (i == 2);
         len   = LW'(3);
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_busy",      32'(busy),      0);
      chk("bp_release_out_valid", 32'(out_valid), 0);
      tick();
      chk("bp_start_ignored", 32'(busy), 0);

      // Zero-length job.
      sb_q.push_back(16'h0000);
      do_start(0, e);
      chk("zero_out_valid", 32'(out_valid), 1);
      chk("zero_out_data",  32'(out_data),  0);
      chk("zero_in_ready",  32'(in_ready),  0);
      tick();
      chk("zero_idle", 32'(busy), 0);

      // Clamp: len=20 consumes exactly MAXK=16 operands of 0x0010.
      sb_q.push_back(16'h0100);
      base = n_acc;
      do_start(20, e);
      for (int i = 0; i < 16; i++) send(16'h0010);
      wait_out(c);
      chk("clamp_latency", 32'(c - e), 16);
      in_valid = 1'b1;
      in_data  = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         chk("clamp_17th_in_ready", 32'(in_ready), 0);
         tick();
      end
      in_valid = 1'b0;
      chk("clamp_consumed", 32'(n_acc - base), 16);

      // Reset after 2 of 4 operands, then a clean single-operand job.
      do_start(4, e);
      send(16'h0100); send(16'h0200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy",      32'(busy),      0);
      chk("midrst_in_ready",  32'(in_ready),  0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_out_data",  32'(out_data),  0);
      sb_q.push_back(16'h8100);
      do_start(1, e);
      send(16'h8100);
      wait_out(c);
      chk("midrst_latency", 32'(c - e), 1);
      tick();

      // Negative zero passes through a single-operand job unaltered.
      sb_q.push_back(16'h8000);
      do_start(1, e);
      send(16'h8000);
      wait_out(c);
      tick();

      // Back-to-back: job B started on the first IDLE cycle after job A.
      sb_q.push_back(16'h0200);
      sb_q.push_back(16'h8040);
      do_start(2, e);
      send(16'h0100); send(16'h0100);
      wait_out(c);
      tick();
      chk("b2b_idle", 32'(busy), 0);
      do_start(1, e2);
      chk("b2b_gap", 32'(e2 - c), 2);
      send(16'h8040);
      wait_out(c2);
      chk("b2b_latency", 32'(c2 - e2), 1);
      tick(); tick();

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
